reg_bus_arbiter: RTL
====================

Name: reg_bus_arbiter

Overview:
- Shares the single 8-bit-address / 32-bit-data register bus between two requesters.
- Requester 0 is the UART-side packet controller; requester 1 is a local on-chip master.
- Arbitrates round-robin, sequences one read or write at a time, waits for read data with a timeout, and returns a response pulse to the owning requester.

Parameters:
- TIMEOUT_CYCLES, default 255: maximum number of WAIT_RD cycles before a read is aborted. Legal range 1..65535; the counter is 16 bits.
- TIMEOUT_DATA, default 32'hDEADBEEF: data returned on a timed-out read.

Ports:
- ipClk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock ipClk
- ipReqValid  in  2  request valid, bit n = requester n
- opReqReady  out  2  request accept; combinational, at most one bit set
- ipReqWrite  in  2  1 = write, 0 = read, per requester
- ipReqAddress0 / ipReqAddress1  in  8  request address
- ipReqWrData0 / ipReqWrData1  in  32  write data
- opRspValid  out  2  one-cycle response pulse to the owner
- opRspData  out  32  read data; 0 for writes
- opRspError  out  1  read timed out; valid with opRspValid
- opBusAddress  out  8  bus address
- opBusWrData  out  32  bus write data
- opBusWrEnable  out  1  one-cycle write strobe
- opBusRdEnable  out  1  one-cycle read strobe
- ipBusRdData  in  32  bus read data
- ipBusRdValid  in  1  read data valid; minimum latency 1 cycle after opBusRdEnable

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Last-grant pointer = 1, so requester 0 wins the first tie.
  - Timeout counter 0.
- States: IDLE, ISSUE, WAIT_RD, RESPOND.
- IDLE:
  - opReqReady = one-hot grant vector; it is 0 in every other state.
  - Grant rules: one valid requester gets the grant. Both valid: the requester not equal to the last-grant pointer wins.
  - Acceptance happens on valid & ready in cycle T. In that cycle the arbiter latches owner, write flag, address and data, updates the pointer to the owner, and moves to ISSUE.
- ISSUE (T+1):
  - Drives opBusAddress and opBusWrData from the latches.
  - Pulses opBusWrEnable or opBusRdEnable for exactly one cycle.
  - Write: go to RESPOND. Read: clear the counter and go to WAIT_RD.
- WAIT_RD:
  - Increments the counter each cycle.
  - ipBusRdValid=1: capture ipBusRdData, set error=0, go to RESPOND.
  - Counter reaches TIMEOUT_CYCLES with no valid: data = TIMEOUT_DATA, error=1, go to RESPOND.
  - ipBusRdValid in the same cycle as the timeout: data wins, error=0.
- RESPOND:
  - opRspValid[owner]=1 for one cycle with opRspData/opRspError.
  - No backpressure; return to IDLE.
  - A new grant is possible in the next cycle.
- Latency:
  - Write accepted at T: bus strobe at T+1, response at T+2.
  - Read with bus latency L: strobe at T+1, data at T+1+L, response at T+2+L.
- opBusAddress/opBusWrData hold their last values between transactions. Strobes are 0 outside ISSUE.
- ipBusRdValid outside WAIT_RD is ignored.
- Requests are never dropped: a non-granted valid request stays pending. Requesters must hold valid and payload until ready.
- Reset mid-transaction:
  - Aborts the transaction; no response is emitted.
  - Strobes are 0 from the first cycle after the reset edge.
  - Pointer returns to 1.

Optional Feature:
- Macro REG_BUS_TIMEOUT_EN.
- Defined: WAIT_RD timeout as above.
- Undefined: the counter is not instantiated. WAIT_RD waits indefinitely for ipBusRdValid, and opRspError is tied to 0.

Test Plan:
- Reset, then requester 0 writes addr 8'h10, data 32'h12345678 -> opReqReady=01 at T; opBusWrEnable=1, addr 10, data 12345678 at T+1; opRspValid=01, opRspData=0 at T+2.
- Requester 1 reads addr 8'h20, bus returns 32'hCAFEF00D with L=3 -> opBusRdEnable at T+1; opRspValid=10, data CAFEF00D, error 0 at T+5.
- Both valid in every cycle, four transactions -> grants alternate 0,1,0,1. No opReqReady overlap, no request lost.
- With REG_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, read with no ipBusRdValid -> response data DEADBEEF, error 1, 6 cycles after acceptance. The same test with ipBusRdValid on the 4th WAIT_RD cycle -> bus data, error 0.
- Reset asserted during WAIT_RD -> no opRspValid. The next tie after reset is granted to requester 0.
- ipBusRdValid pulsed while IDLE, then a write -> the write response has opRspData=0 and opRspError=0.

Source files
------------

// File: rtl/reg_bus_arbiter_if.sv
// reg_bus_arbiter_if: requester handshake and register-bus signals of reg_bus_arbiter.
// Modport master is the arbiter's view; modport slave is the requesters' and bus target's view.
interface reg_bus_arbiter_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  // Requester side
  logic [1:0]        ipReqValid;
  logic [1:0]        opReqReady;
  logic [1:0]        ipReqWrite;
  logic [ADDR_W-1:0] ipReqAddress0;
  logic [ADDR_W-1:0] ipReqAddress1;
  logic [DATA_W-1:0] ipReqWrData0;
  logic [DATA_W-1:0] ipReqWrData1;
  logic [1:0]        opRspValid;
  logic [DATA_W-1:0] opRspData;
  logic              opRspError;

  // Register bus side
  logic [ADDR_W-1:0] opBusAddress;
  logic [DATA_W-1:0] opBusWrData;
  logic              opBusWrEnable;
  logic              opBusRdEnable;
  logic [DATA_W-1:0] ipBusRdData;
  logic              ipBusRdValid;

  modport master (
    input  ipReqValid, ipReqWrite, ipReqAddress0, ipReqAddress1,
           ipReqWrData0, ipReqWrData1, ipBusRdData, ipBusRdValid,
    output opReqReady, opRspValid, opRspData, opRspError,
           opBusAddress, opBusWrData, opBusWrEnable, opBusRdEnable
  );

  modport slave (
    output ipReqValid, ipReqWrite, ipReqAddress0, ipReqAddress1,
           ipReqWrData0, ipReqWrData1, ipBusRdData, ipBusRdValid,
    input  opReqReady, opRspValid, opRspData, opRspError,
           opBusAddress, opBusWrData, opBusWrEnable, opBusRdEnable
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares the 8-bit address / 32-bit data register bus between
// requester 0 (UART packet controller) and requester 1 (local master), round-robin,
// one transaction at a time. Define REG_BUS_TIMEOUT_EN to compile in the read
// timeout (TIMEOUT_CYCLES / TIMEOUT_DATA); without it reads wait indefinitely.
module reg_bus_arbiter #(
`ifdef REG_BUS_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF,
`endif
  parameter int unsigned NUM_REQ        = 2
) (
  input  logic              ipClk,
  input  logic              reset,
  reg_bus_arbiter_if.master bus
);
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  // The arbiter is a fixed two-way design; NUM_REQ documents and guards that
  if (NUM_REQ != 2) begin : g_bad_num_req
    $error("reg_bus_arbiter: NUM_REQ=%0d, only 2 is supported", NUM_REQ);
  end

`ifdef REG_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;

  // The wait counter is 16 bits, so the timeout must fit in it
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("reg_bus_arbiter: TIMEOUT_CYCLES=%0d outside 1..65535", TIMEOUT_CYCLES);
  end
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESPOND} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              write_q, write_d;
  logic              last_q, last_d;
  logic [1:0]        grant_c;
  logic [1:0]        rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_d;
  logic              wr_en_d;
  logic              rd_en_d;
`ifdef REG_BUS_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_error_d;
`endif

  // Round-robin grant, offered only while IDLE; on a tie the requester not granted last wins
  always_comb begin
    grant_c = 2'b00;
    if (state_q == IDLE) begin
      case (bus.ipReqValid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = last_q ? 2'b01 : 2'b10;
        default: grant_c = 2'b00;
      endcase
    end
  end

  assign bus.opReqReady = grant_c;

  // Next state and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    last_d      = last_q;
    bus_addr_d  = bus.opBusAddress;
    bus_wdata_d = bus.opBusWrData;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    rsp_valid_d = 2'b00;
    rsp_data_d  = '0;
`ifdef REG_BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_error_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (grant_c != 2'b00) begin
          owner_d     = grant_c[1];
          last_d      = grant_c[1];
          write_d     = bus.ipReqWrite[grant_c[1]];
          bus_addr_d  = grant_c[1] ? bus.ipReqAddress1 : bus.ipReqAddress0;
          bus_wdata_d = grant_c[1] ? bus.ipReqWrData1  : bus.ipReqWrData0;
          wr_en_d     = write_d;
          rd_en_d     = ~write_d;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (write_q) begin
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          state_d     = RESPOND;
        end else begin
`ifdef REG_BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
`ifdef REG_BUS_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        // Read data takes priority over a timeout landing in the same cycle
        if (bus.ipBusRdValid) begin
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_data_d  = bus.ipBusRdData;
          state_d     = RESPOND;
        end
`ifdef REG_BUS_TIMEOUT_EN
        else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_data_d  = TIMEOUT_DATA;
          rsp_error_d = 1'b1;
          state_d     = RESPOND;
        end
`endif
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, transaction latches and registered outputs; reset aborts any transaction
  always_ff @(posedge ipClk) begin
    if (reset) begin
      state_q           <= IDLE;
      owner_q           <= 1'b0;
      write_q           <= 1'b0;
      last_q            <= 1'b1;
      bus.opBusAddress  <= '0;
      bus.opBusWrData   <= '0;
      bus.opBusWrEnable <= 1'b0;
      bus.opBusRdEnable <= 1'b0;
      bus.opRspValid    <= 2'b00;
      bus.opRspData     <= '0;
`ifdef REG_BUS_TIMEOUT_EN
      bus.opRspError    <= 1'b0;
      cnt_q             <= '0;
`endif
    end else begin
      state_q           <= state_d;
      owner_q           <= owner_d;
      write_q           <= write_d;
      last_q            <= last_d;
      bus.opBusAddress  <= bus_addr_d;
      bus.opBusWrData   <= bus_wdata_d;
      bus.opBusWrEnable <= wr_en_d;
      bus.opBusRdEnable <= rd_en_d;
      bus.opRspValid    <= rsp_valid_d;
      bus.opRspData     <= rsp_data_d;
`ifdef REG_BUS_TIMEOUT_EN
      bus.opRspError    <= rsp_error_d;
      cnt_q             <= cnt_d;
`endif
    end
  end

`ifndef REG_BUS_TIMEOUT_EN
  // Without the timeout a read can never fail
  assign bus.opRspError = 1'b0;
`endif

endmodule
